// File: rtl/word_serializer.sv
// Parallel-to-serial unloader: captures a word on an accepted load and shifts it
// out one bit per enabled clock, flagging valid and last bits.
module word_serializer #(
  parameter int N         = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  input  logic         shift_en,
  output logic         ready,
  output logic         sout,
  output logic         sout_valid,
  output logic         last
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state, state_n;
  logic [N-1:0]  sreg, sreg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          at_end;
  logic          accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      cnt   <= cnt_n;
    end
  end

  // The shift register moves the next bit into a fixed tap, so sout needs no
  // counter-indexed mux; the counter only tracks word position for last.
  always_comb begin
    sout_valid = (state == SHIFT);
    at_end     = sout_valid && (cnt == CW'(N - 1));
    last       = at_end;
    ready      = !rst && ((state == IDLE) || (at_end && shift_en));
    accept     = load && ready;
    sout       = sout_valid && ((LSB_FIRST != 0) ? sreg[0] : sreg[N-1]);

    state_n = state;
    sreg_n  = sreg;
    cnt_n   = cnt;
    if (accept) begin
      state_n = SHIFT;
      sreg_n  = d;
      cnt_n   = '0;
    end else if ((state == SHIFT) && shift_en) begin
      if (at_end) begin
        state_n = IDLE;
      end else begin
        sreg_n = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);
        cnt_n  = cnt + CW'(1);
      end
    end
  end

endmodule
